// File: rtl/fp_defs.sv
// Shared definitions for the serial normalizer: default widths, exponent limit and FSM encoding.
package fp_defs;
    localparam int MANT_W  = 24;
    localparam int EXP_W   = 8;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/serial_normalizer_if.sv
// Request/result bundle between a requester (master) and the serial normalizer (slave).
interface serial_normalizer_if #(
    parameter int MANT_W = fp_defs::MANT_W,
    parameter int EXP_W  = fp_defs::EXP_W
);
    logic              Start;
    logic [MANT_W:0]   Data;
    logic [EXP_W-1:0]  Exp;
    logic              Busy;
    logic              Done;
    logic [MANT_W-1:0] Result;
    logic [EXP_W-1:0]  Exp_out;
    logic [4:0]        Count;
    logic              Direction;
    logic              Zero;
    logic              Underflow;
    logic              Overflow;

    modport master (
        output Start, Data, Exp,
        input  Busy, Done, Result, Exp_out, Count, Direction, Zero, Underflow, Overflow
    );

    modport slave (
        input  Start, Data, Exp,
        output Busy, Done, Result, Exp_out, Count, Direction, Zero, Underflow, Overflow
    );
endinterface

// File: rtl/shift_counter_5bit.sv
// 5-bit shift-distance counter: async reset, synchronous clear (wins over enable), count enable.
module shift_counter_5bit (
    input  logic       Clk,
    input  logic       Clear_n,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [4:0] count_o
);
    logic [4:0] count_q;
    logic [4:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (en_i)
            count_d = count_q + 5'd1;
    end

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;
endmodule

// File: rtl/serial_normalizer.sv
// Iterative mantissa normalizer: one right shift for a carry-out, or one left shift per cycle
// until the leading one reaches bit MANT_W-1 or the exponent bottoms out.
module serial_normalizer #(
    parameter int MANT_W = fp_defs::MANT_W,
    parameter int EXP_W  = fp_defs::EXP_W
) (
    input logic                Clk,
    input logic                Clear_n,
    serial_normalizer_if.slave bus
);
    import fp_defs::*;

    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
    localparam logic [EXP_W-1:0] EXP_OVF = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [4:0]       CNT_MAX = 5'(MANT_W - 1);

    state_t           state_q;
    logic [MANT_W:0]  mant_q;
    logic [EXP_W-1:0] exp_q;
    logic             busy_q, done_q, dir_q, zero_q, unf_q, ovf_q;

    logic       in_norm, accept;
    logic       is_zero, exp_zero, is_carry, is_norm, exp_one, norm_end;
    logic       cnt_clr, cnt_en;
    logic [4:0] cnt;

    assign in_norm  = (state_q == ST_NORM);
    assign accept   = bus.Start && !in_norm;
    assign is_zero  = (mant_q == '0);
    assign exp_zero = (exp_q == '0);
    assign is_carry = mant_q[MANT_W];
    assign is_norm  = mant_q[MANT_W-1];
    assign exp_one  = (exp_q == EXP_ONE);
    assign norm_end = is_zero || exp_zero || is_carry || is_norm || exp_one;

    // Counter steps once for the carry right shift and once per left shift.
    assign cnt_clr = accept;
    assign cnt_en  = in_norm && !exp_zero && (is_carry || !norm_end) && (cnt != CNT_MAX);

    shift_counter_5bit u_cnt (
        .Clk     (Clk),
        .Clear_n (Clear_n),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (cnt)
    );

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            state_q <= ST_IDLE;
            mant_q  <= '0;
            exp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= 1'b0;
            zero_q  <= 1'b0;
            unf_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_NORM: begin
                    if (norm_end) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0 | 1'b1;
                    end
                    if (is_zero) begin
                        zero_q <= 1'b1;
                        exp_q  <= '0;
                    end else if (exp_zero) begin
                        // A zero exponent on a nonzero value is denormal from the start.
                        unf_q <= 1'b1;
                    end else if (is_carry) begin
                        dir_q <= 1'b0;
                        if (exp_q == EXP_OVF) begin
                            ovf_q  <= 1'b1;
                            exp_q  <= '1;
                            mant_q <= '0;
                        end else begin
                            mant_q <= {1'b0, mant_q[MANT_W:1]};
                            exp_q  <= exp_q + EXP_ONE;
                        end
                    end else if (is_norm) begin
                        exp_q <= exp_q;
                    end else if (exp_one) begin
                        exp_q <= '0;
                        unf_q <= 1'b1;
                    end else begin
                        mant_q <= {mant_q[MANT_W-1:0], 1'b0};
                        exp_q  <= exp_q - EXP_ONE;
                        dir_q  <= 1'b1;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q <= ST_NORM;
                        busy_q  <= 1'b1;
                        mant_q  <= bus.Data;
                        exp_q   <= bus.Exp;
                        dir_q   <= 1'b0;
                        zero_q  <= 1'b0;
                        unf_q   <= 1'b0;
                        ovf_q   <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Result    = mant_q[MANT_W-1:0];
    assign bus.Exp_out   = exp_q;
    assign bus.Count     = cnt;
    assign bus.Direction = dir_q;
    assign bus.Zero      = zero_q;
    assign bus.Underflow = unf_q;
    assign bus.Overflow  = ovf_q;
endmodule

// File: tb/tb_serial_normalizer.sv
// Directed vector bench for serial_normalizer: table of single operations plus
// busy-ignore, back-to-back and mid-operation reset sequences.
module tb_serial_normalizer;
    logic Clk;
    logic Clear_n;
    int   total;
    int   bad;

    serial_normalizer_if #(.MANT_W(24), .EXP_W(8)) bus ();

    serial_normalizer #(.MANT_W(24), .EXP_W(8)) dut (
        .Clk     (Clk),
        .Clear_n (Clear_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [24:0] data;
        logic [7:0]  ex;
        int          lat;
        logic [23:0] res;
        logic [7:0]  eo;
        logic [4:0]  cnt;
        logic        dir;
        logic        zero;
        logic        unf;
        logic        ovf;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic issue(input logic [24:0] d, input logic [7:0] e);
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Data  = d;
        bus.Exp   = e;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
    endtask

    // Returns the number of edges after the Start edge until Done is seen (bounded).
    task automatic wait_done(input int already, output int edges);
        edges = already;
        while (!bus.Done && edges < 60) begin
            @(posedge Clk);
            #1;
            edges++;
        end
    endtask

    task automatic check_out(input vec_t v, input int edges, input string tag);
        chk({tag, "_latency"}, edges, v.lat);
        chk({tag, "_result"}, bus.Result, v.res);
        chk({tag, "_exp_out"}, bus.Exp_out, v.eo);
        chk({tag, "_count"}, bus.Count, v.cnt);
        chk({tag, "_direction"}, bus.Direction, v.dir);
        chk({tag, "_zero"}, bus.Zero, v.zero);
        chk({tag, "_underflow"}, bus.Underflow, v.unf);
        chk({tag, "_overflow"}, bus.Overflow, v.ovf);
        $display("%s data=%h exp=%0d -> lat=%0d result=%h exp_out=%0d count=%0d dir=%0b z=%0b u=%0b o=%0b",
                 tag, v.data, v.ex, edges, bus.Result, bus.Exp_out, bus.Count,
                 bus.Direction, bus.Zero, bus.Underflow, bus.Overflow);
    endtask

    task automatic check_pulse_end(input string tag);
        @(posedge Clk);
        #1;
        chk({tag, "_done_fall"}, bus.Done, 1'b0);
        chk({tag, "_busy_idle"}, bus.Busy, 1'b0);
    endtask

    initial begin
        int   edges;
        logic done_seen;
        vec_t v;

        total     = 0;
        bad       = 0;
        Clear_n   = 1'b0;
        bus.Start = 1'b0;
        bus.Data  = '0;
        bus.Exp   = '0;

        vecs[0]  = '{25'h0800000, 8'd127, 1,  24'h800000, 8'd127, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{25'h1000001, 8'd100, 1,  24'h800000, 8'd101, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{25'h0000100, 8'd127, 16, 24'h800000, 8'd112, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{25'h0000000, 8'd50,  1,  24'h000000, 8'd0,   5'd0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{25'h1000000, 8'd254, 1,  24'h000000, 8'd255, 5'd1,  1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{25'h0000001, 8'd5,   5,  24'h000010, 8'd0,   5'd4,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{25'h0000100, 8'd0,   1,  24'h000100, 8'd0,   5'd0,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{25'h0000001, 8'd127, 24, 24'h800000, 8'd104, 5'd23, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{25'h1FFFFFF, 8'd10,  1,  24'hFFFFFF, 8'd11,  5'd1,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{25'h0400000, 8'd2,   2,  24'h800000, 8'd1,   5'd1,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{25'h0400000, 8'd1,   1,  24'h400000, 8'd0,   5'd0,  1'b0, 1'b0, 1'b1, 1'b0};

        repeat (3) @(posedge Clk);
        #1;
        chk("rst_result", bus.Result, 24'h0);
        chk("rst_exp_out", bus.Exp_out, 8'h0);
        chk("rst_count", bus.Count, 5'h0);
        chk("rst_busy", bus.Busy, 1'b0);
        chk("rst_done", bus.Done, 1'b0);
        chk("rst_flags", {bus.Direction, bus.Zero, bus.Underflow, bus.Overflow}, 4'h0);
        @(negedge Clk);
        Clear_n = 1'b1;
        repeat (2) @(posedge Clk);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].data, vecs[i].ex);
            chk($sformatf("vec%0d_busy", i), bus.Busy, 1'b1);
            wait_done(0, edges);
            check_out(vecs[i], edges, $sformatf("vec%0d", i));
            check_pulse_end($sformatf("vec%0d", i));
        end

        // Start while busy must be ignored.
        issue(vecs[5].data, vecs[5].ex);
        bus.Start = 1'b1;
        bus.Data  = 25'h1000000;
        bus.Exp   = 8'd254;
        repeat (3) begin
            @(posedge Clk);
            #1;
        end
        bus.Start = 1'b0;
        wait_done(3, edges);
        check_out(vecs[5], edges, "busy_ignore");
        check_pulse_end("busy_ignore");

        // Back-to-back: Start presented in the Done cycle.
        issue(vecs[0].data, vecs[0].ex);
        wait_done(0, edges);
        check_out(vecs[0], edges, "b2b_first");
        bus.Start = 1'b1;
        bus.Data  = vecs[1].data;
        bus.Exp   = vecs[1].ex;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        chk("b2b_done_fall", bus.Done, 1'b0);
        chk("b2b_busy", bus.Busy, 1'b1);
        wait_done(0, edges);
        check_out(vecs[1], edges, "b2b_second");
        check_pulse_end("b2b_second");

        // Asynchronous reset in the middle of a 15-shift operation.
        issue(vecs[2].data, vecs[2].ex);
        repeat (2) begin
            @(posedge Clk);
            #1;
        end
        bus.Start = 1'b1;
        bus.Data  = 25'h0800000;
        bus.Exp   = 8'd1;
        repeat (3) begin
            @(posedge Clk);
            #1;
        end
        chk("abort_busy_mid", bus.Busy, 1'b1);
        chk("abort_count_mid", bus.Count, 5'd5);
        chk("abort_result_mid", bus.Result, 24'h002000);
        chk("abort_exp_mid", bus.Exp_out, 8'd122);
        #1;
        Clear_n = 1'b0;
        #1;
        chk("abort_result", bus.Result, 24'h0);
        chk("abort_exp_out", bus.Exp_out, 8'h0);
        chk("abort_count", bus.Count, 5'h0);
        chk("abort_busy", bus.Busy, 1'b0);
        chk("abort_done", bus.Done, 1'b0);
        $display("abort reset asserted mid-operation: result=%h count=%0d", bus.Result, bus.Count);
        bus.Start = 1'b0;
        @(negedge Clk);
        Clear_n = 1'b1;
        done_seen = 1'b0;
        repeat (30) begin
            @(posedge Clk);
            #1;
            if (bus.Done) done_seen = 1'b1;
        end
        chk("abort_no_done", done_seen, 1'b0);
        v = vecs[2];
        issue(v.data, v.ex);
        wait_done(0, edges);
        check_out(v, edges, "after_abort");
        check_pulse_end("after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_normalizer.md
SERIAL_NORMALIZER -- requirements
Module: serial_normalizer

Interface
REQ-001 SHALL have parameter MANT_W, default 24, mantissa width including hidden bit.
REQ-002 SHALL have parameter EXP_W, default 8, biased exponent width.
REQ-003 Clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Clear_n  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  request strobe, accepted only when Busy=0.
REQ-006 Data  input  MANT_W+1  raw adder sum; bit MANT_W is the carry-out.
REQ-007 Exp  input  EXP_W  exponent of the larger operand.
REQ-008 Busy  output  1  high while in NORM state.
REQ-009 Done  output  1  one-cycle completion pulse.
REQ-010 Result  output  MANT_W  normalized mantissa, held until next accepted Start.
REQ-011 Exp_out  output  EXP_W  adjusted exponent, held until next accepted Start.
REQ-012 Count  output  5  total shift distance applied.
REQ-013 Direction  output  1  0 = right shift (carry), 1 = left shift.
REQ-014 Zero, Underflow, Overflow  output  1 each  status flags, held with Result.

Function
REQ-015 SHALL implement FSM states IDLE, NORM, DONE.
- IDLE/DONE + Start: latch Data and Exp; clear Count, Direction and flags; go to NORM.
- DONE without Start: go to IDLE.
REQ-016 In NORM, SHALL evaluate each cycle in this priority order:
- (a) latched value ==0: Zero=1, Result=0, Exp_out=0 -> DONE.
- (b) bit MANT_W=1: shift right 1 with LSB truncated, Exp+1, Count=1, Direction=0 -> DONE.
- (c) bit MANT_W-1=1 -> DONE.
- (d) exponent==1: Exp_out=0, Underflow=1, mantissa left unshifted -> DONE.
- (e) otherwise: shift left 1, exponent-1, Count+1, Direction=1, stay in NORM.
REQ-017 In case (b) with Exp=2^EXP_W-2, SHALL set Overflow=1, Exp_out=all ones, Result=0.
REQ-018 Latency: with the Start-sampling edge counted as edge 0 and L left shifts needed, Done SHALL be high in the cycle after edge L+1 (cases a/b/c: after edge 1).
REQ-019 Done SHALL be high for exactly one cycle; Busy SHALL be high in NORM only.
REQ-020 Start while Busy=1 SHALL be ignored with no effect on state or outputs.
REQ-021 Start in the DONE cycle SHALL be accepted (back-to-back operation); Done SHALL fall the next cycle.
REQ-022 Count SHALL never exceed MANT_W-1 and SHALL not wrap.
REQ-023 Exp input 0 with nonzero Data SHALL take path (d) immediately: Exp_out=0, Underflow=1.

Reset
REQ-024 Clear_n low SHALL asynchronously force state IDLE and drive all outputs, internal registers and flags to 0.
REQ-025 Reset mid-NORM SHALL abort the operation with no Done pulse; the first Start after release SHALL be processed normally.

Structure
REQ-026 MANT_W, EXP_W, EXP_MAX and the FSM state encodings SHALL live in the shared fp_defs package/header.
REQ-027 The shift-distance counter SHALL be a sub-module shift_counter_5bit: 5-bit up-counter with synchronous clear and enable, plus async Clear_n.
REQ-028 Mantissa and exponent SHALL be iterative registers (one bit per cycle); no barrel shifter.

Verification
REQ-029 Data=25'h0800000, Exp=127: Done after edge 1; Result=24'h800000, Exp_out=127, Count=0.
REQ-030 Data=25'h1000001, Exp=100: Done after edge 1; Result=24'h800000, Exp_out=101, Count=1, Direction=0.
REQ-031 Data=25'h0000100, Exp=127: Done after edge 16; Result=24'h800000, Exp_out=112, Count=15, Direction=1.
REQ-032 Data=0: Zero=1, Result=0, Exp_out=0. Data=25'h1000000, Exp=254: Overflow=1, Exp_out=255, Result=0.
REQ-033 Data=25'h0000001, Exp=5: 4 shifts, Result=24'h000010, Exp_out=0, Underflow=1, Count=4.
REQ-034 Clear_n pulsed at edge 5 of REQ-031 with Start re-issued during the operation: outputs immediately 0, no Done; the next Start gives the REQ-031 result.
